// File: rtl/ram_loader_if.sv
// Byte-stream handshake, shared-bus strobes and session status between the
// program source / CPU side (master) and the RAM loader (slave).
interface ram_loader_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              abort;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        bus_out;
  logic              bus_oe;
  logic              MI;
  logic              RI;
  logic              halt_cpu;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        checksum;

  modport master (
    output start, abort, in_data, in_valid,
    input  in_ready, bus_out, bus_oe, MI, RI, halt_cpu, busy, done, addr, checksum
  );

  modport slave (
    input  start, abort, in_data, in_valid,
    output in_ready, bus_out, bus_oe, MI, RI, halt_cpu, busy, done, addr, checksum
  );
endinterface

// File: rtl/ram_loader.sv
// Loads a stream of program bytes into RAM words 0..WORDS-1, driving each write
// as an MI (address) phase followed by an RI (data) phase while the CPU is halted.
module ram_loader #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  ram_loader_if.slave lif
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_checksum;
  logic [7:0]        r_byte;

  logic              w_last;
  logic              w_accept;
  logic              w_in_ready;
  logic [7:0]        w_bus_out;
  logic              w_bus_oe;
  logic              w_mi;
  logic              w_ri;
  logic              w_done;

  assign w_last   = (r_addr == ADDR_W'(WORDS - 1));
  // abort wins over the handshake, so a byte offered alongside it is dropped
  assign w_accept = (r_state == WAIT_BYTE) && lif.in_valid && !lif.abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_bus_out  = 8'h00;
    w_bus_oe   = 1'b0;
    w_mi       = 1'b0;
    w_ri       = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (lif.start) w_next = WAIT_BYTE;
      end
      WAIT_BYTE: begin
        w_in_ready = 1'b1;
        if (lif.abort)         w_next = IDLE;
        else if (lif.in_valid) w_next = ADDR;
      end
      ADDR: begin
        w_bus_out = 8'(r_addr);
        w_bus_oe  = 1'b1;
        w_mi      = 1'b1;
        w_next    = lif.abort ? IDLE : DATA;
      end
      DATA: begin
        w_bus_out = r_byte;
        w_bus_oe  = 1'b1;
        w_ri      = 1'b1;
        if (lif.abort)   w_next = IDLE;
        else if (w_last) w_next = DONE;
        else             w_next = WAIT_BYTE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The DATA-phase write always completes, even when aborted, so it is always counted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_checksum <= 8'h00;
      r_byte     <= 8'h00;
    end else begin
      if (r_state == IDLE && lif.start) begin
        r_addr     <= '0;
        r_checksum <= 8'h00;
      end
      if (w_accept) begin
        r_byte <= lif.in_data;
      end
      if (r_state == DATA) begin
        r_checksum <= r_checksum + r_byte;
        r_addr     <= w_last ? '0 : r_addr + ADDR_W'(1);
      end
    end
  end

  assign lif.in_ready = w_in_ready;
  assign lif.bus_out  = w_bus_out;
  assign lif.bus_oe   = w_bus_oe;
  assign lif.MI       = w_mi;
  assign lif.RI       = w_ri;
  assign lif.done     = w_done;
  assign lif.busy     = (r_state != IDLE);
  assign lif.halt_cpu = (r_state != IDLE);
  assign lif.addr     = r_addr;
  assign lif.checksum = r_checksum;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: a transaction-level model predicts every
// output each cycle, and directed scenarios pin key values by hand.
module tb_ram_loader;

  localparam int WORDS  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ram_loader_if #(.ADDR_W(ADDR_W)) lif ();

  ram_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .lif (lif)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  int startCyc    = 0;
  int doneCyc     = 0;
  int miCount     = 0;
  int riCount     = 0;
  int doneCount   = 0;
  bit cmpEn       = 1'b0;

  logic [7:0] ram [WORDS];
  logic [3:0] mar;
  logic [3:0] miAddrs [$];
  logic [7:0] riData  [$];

  // Model: a session is "busy", optionally holding one pending byte that is
  // 1 cycle old (address phase) or 2 cycles old (data phase).
  bit         mBusy;
  bit         mDoneNow;
  bit         mPend;
  int         mAge;
  logic [7:0] mByte;
  int         mCount;
  int         mSum;
  logic [7:0] mMem [WORDS];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic val, input logic [7:0] dat);
    lif.start    = st;
    lif.abort    = ab;
    lif.in_valid = val;
    lif.in_data  = dat;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mBusy = 0; mDoneNow = 0; mPend = 0; mAge = 0; mCount = 0; mSum = 0;
    end else if (mDoneNow) begin
      mDoneNow = 0;
    end else if (!mBusy) begin
      if (lif.start) begin mBusy = 1; mCount = 0; mSum = 0; end
    end else if (!mPend) begin
      if (lif.abort) mBusy = 0;
      else if (lif.in_valid) begin mPend = 1; mAge = 1; mByte = lif.in_data; end
    end else if (mAge == 1) begin
      if (lif.abort) begin mBusy = 0; mPend = 0; end
      else mAge = 2;
    end else begin
      mMem[mCount % WORDS] = mByte;
      mSum   = (mSum + int'(mByte)) % 256;
      mCount = mCount + 1;
      mPend  = 0;
      if (lif.abort) mBusy = 0;
      else if (mCount == WORDS) begin mBusy = 0; mDoneNow = 1; end
    end
  end

  // RAM/MAR model and pulse bookkeeping, using the values present just before the edge
  always @(posedge clk) begin
    if (lif.MI) begin
      mar = lif.bus_out[3:0];
      miCount++;
      miAddrs.push_back(lif.bus_out[3:0]);
    end
    if (lif.RI) begin
      ram[mar] = lif.bus_out;
      riCount++;
      riData.push_back(lif.bus_out);
    end
    if (lif.done) begin
      doneCount++;
      doneCyc = cyc;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cmpEn) begin
      logic       eMI, eRI, eBusy;
      logic [7:0] eBus;
      eBusy = mBusy || mDoneNow;
      eMI   = mPend && (mAge == 1);
      eRI   = mPend && (mAge == 2);
      eBus  = eMI ? 8'(mCount % WORDS) : (eRI ? mByte : 8'h00);
      checkOutput("in_ready", lif.in_ready, mBusy && !mPend);
      checkOutput("bus_out",  lif.bus_out,  eBus);
      checkOutput("bus_oe",   lif.bus_oe,   eMI || eRI);
      checkOutput("MI",       lif.MI,       eMI);
      checkOutput("RI",       lif.RI,       eRI);
      checkOutput("busy",     lif.busy,     eBusy);
      checkOutput("halt_cpu", lif.halt_cpu, eBusy);
      checkOutput("done",     lif.done,     mDoneNow);
      checkOutput("addr",     lif.addr,     mCount % WORDS);
      checkOutput("checksum", lif.checksum, mSum);
      checkOutput("MI&RI exclusive",  lif.MI & lif.RI, 1'b0);
      checkOutput("bus_oe==MI|RI",    lif.bus_oe, lif.MI | lif.RI);
      checkOutput("halt_cpu==busy",   lif.halt_cpu, lif.busy);
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " in_ready"}, lif.in_ready, 0);
    checkOutput({tag, " bus_out"},  lif.bus_out,  0);
    checkOutput({tag, " bus_oe"},   lif.bus_oe,   0);
    checkOutput({tag, " MI"},       lif.MI,       0);
    checkOutput({tag, " RI"},       lif.RI,       0);
    checkOutput({tag, " halt_cpu"}, lif.halt_cpu, 0);
    checkOutput({tag, " busy"},     lif.busy,     0);
    checkOutput({tag, " done"},     lif.done,     0);
  endtask

  task automatic startSession();
    applyStimulus(1, 0, 0, 8'h00);
    startCyc = cyc;
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00);
  endtask

  // Offers n bytes (base + step*index); gap>0 offers a byte only every gap-th cycle.
  task automatic feed(input int n, input logic [7:0] base, input logic [7:0] step,
                      input int gap, input int midStartIdx, input int maxCyc);
    int   idx = 0;
    int   c = 0;
    bit   pulsed = 0;
    logic val, rdy, st;
    while (idx < n && c < maxCyc) begin
      val = (gap == 0) ? 1'b1 : ((c % gap) == 0);
      st  = (idx == midStartIdx) && !pulsed;
      if (st) pulsed = 1;
      applyStimulus(st, 0, val, 8'(base + step * 8'(idx)));
      rdy = lif.in_ready;
      nextCycle();
      if (rdy && val) idx++;
      c++;
    end
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("bytes accepted", idx, n);
  endtask

  task automatic waitIdle(input int maxCyc);
    int c = 0;
    while (lif.busy && c < maxCyc) begin nextCycle(); c++; end
    checkOutput("session ends in budget", lif.busy, 0);
  endtask

  task automatic waitSignal(input int which, input int maxCyc);
    int c = 0;
    while (c < maxCyc && !((which == 0 && lif.in_ready) || (which == 1 && lif.MI) ||
                           (which == 2 && lif.RI))) begin
      nextCycle();
      c++;
    end
    checkOutput("phase reached in budget", c < maxCyc, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int miB, riB, dnB;
    for (int i = 0; i < WORDS; i++) begin ram[i] = 8'h00; mMem[i] = 8'h00; end
    mar = 4'h0;
    applyStimulus(0, 0, 0, 8'h00);
    #1 rst = 1'b0;
    #1 cmpEn = 1'b1;
    #20;
    checkAllZero("reset");
    checkOutput("reset addr", lif.addr, 0);
    checkOutput("reset checksum", lif.checksum, 0);
    nextCycle();
    rst = 1'b1;
    nextCycle();

    // Full load, back-to-back
    miAddrs.delete(); riData.delete(); dnB = doneCount;
    startSession();
    feed(16, 8'h00, 8'h01, 0, -1, 100);
    waitIdle(20);
    checkOutput("full MI pulses", miAddrs.size(), 16);
    checkOutput("full RI pulses", riData.size(), 16);
    for (int i = 0; i < 16 && i < miAddrs.size() && i < riData.size(); i++) begin
      checkOutput("full MI addr", miAddrs[i], i);
      checkOutput("full RI data", riData[i], i);
      checkOutput("full ram", ram[i], i);
    end
    checkOutput("full done count", doneCount - dnB, 1);
    checkOutput("full done cycle", doneCyc - startCyc + 1, 50);
    checkOutput("full checksum", lif.checksum, 8'h78);

    // Throttled source
    miB = miCount; riB = riCount;
    startSession();
    feed(16, 8'hA5, 8'h00, 5, -1, 400);
    waitIdle(20);
    checkOutput("throttled MI pulses", miCount - miB, 16);
    checkOutput("throttled RI pulses", riCount - riB, 16);
    checkOutput("throttled checksum", lif.checksum, 8'h50);
    checkOutput("throttled ram[7]", ram[7], 8'hA5);

    // Abort in WAIT_BYTE after 3 words, with a byte offered at the same time
    riB = riCount; dnB = doneCount;
    startSession();
    feed(3, 8'h10, 8'h01, 0, -1, 30);
    waitSignal(0, 10);
    applyStimulus(0, 1, 1, 8'h77);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("abort-wait busy", lif.busy, 0);
    checkOutput("abort-wait addr", lif.addr, 3);
    checkOutput("abort-wait checksum", lif.checksum, 8'h33);
    repeat (3) nextCycle();
    checkOutput("abort-wait writes", riCount - riB, 3);
    checkOutput("abort-wait no done", doneCount - dnB, 0);

    // Abort in ADDR
    riB = riCount;
    startSession();
    applyStimulus(0, 0, 1, 8'h5A);
    waitSignal(1, 10);
    applyStimulus(0, 1, 0, 8'h00);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00);
    repeat (3) nextCycle();
    checkOutput("abort-addr no RI", riCount - riB, 0);
    checkOutput("abort-addr busy", lif.busy, 0);
    checkOutput("abort-addr addr", lif.addr, 0);

    // Abort in DATA
    riB = riCount; dnB = doneCount;
    startSession();
    applyStimulus(0, 0, 1, 8'hC3);
    waitSignal(2, 10);
    applyStimulus(0, 1, 0, 8'h00);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("abort-data busy", lif.busy, 0);
    checkOutput("abort-data checksum", lif.checksum, 8'hC3);
    checkOutput("abort-data addr", lif.addr, 1);
    checkOutput("abort-data ram[0]", ram[0], 8'hC3);
    checkOutput("abort-data writes", riCount - riB, 1);
    checkOutput("abort-data no done", doneCount - dnB, 0);

    // Start while busy, then run to completion; session overwrites RAM
    miB = miCount; dnB = doneCount;
    startSession();
    checkOutput("restart checksum", lif.checksum, 0);
    feed(16, 8'hF0, 8'hFF, 0, 5, 100);
    waitIdle(20);
    checkOutput("restart MI pulses", miCount - miB, 16);
    checkOutput("restart done count", doneCount - dnB, 1);
    checkOutput("restart addr wraps", lif.addr, 0);
    checkOutput("restart checksum end", lif.checksum, 8'h88);
    for (int i = 0; i < WORDS; i++) begin
      logic [7:0] expv;
      expv = 8'hF0 - 8'(i);
      checkOutput("restart ram", ram[i], expv);
    end

    // Asynchronous reset in the middle of a DATA cycle
    startSession();
    applyStimulus(0, 0, 1, 8'h99);
    waitSignal(2, 10);
    applyStimulus(0, 0, 0, 8'h00);
    #2 rst = 1'b0;
    #1;
    checkOutput("async bus_oe", lif.bus_oe, 0);
    checkOutput("async RI", lif.RI, 0);
    checkOutput("async busy", lif.busy, 0);
    repeat (3) nextCycle();
    checkAllZero("held reset");
    checkOutput("held reset addr", lif.addr, 0);
    checkOutput("held reset checksum", lif.checksum, 0);
    checkOutput("reset keeps ram[0]", ram[0], 8'hF0);
    rst = 1'b1;
    applyStimulus(0, 0, 1, 8'h42);
    repeat (4) nextCycle();
    checkOutput("post-reset idle busy", lif.busy, 0);
    checkOutput("post-reset idle in_ready", lif.in_ready, 0);
    startSession();
    checkOutput("post-reset new start", lif.busy, 1);

    // Random start/abort/valid traffic
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 2) == 1, 8'($urandom));
      nextCycle();
    end
    applyStimulus(0, 1, 0, 8'h00);
    nextCycle();
    applyStimulus(0, 0, 0, 8'h00);
    waitIdle(10);
    for (int i = 0; i < WORDS; i++) begin
      checkOutput("random ram vs model", ram[i], mMem[i]);
    end

    cmpEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
